// File: rtl/seq_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_shifter                                                  |
// | Description : Multi-cycle logical/arithmetic/rotate shifter, STEP bits per |
// |               clock, start/busy/done handshake and carry-out flag.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    amt,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sout,
    output logic             carry
);

    localparam int            c_kw    = AW + 1;
    localparam logic [c_kw-1:0] c_step  = c_kw'(STEP);
    localparam logic [c_kw-1:0] c_width = c_kw'(WIDTH);

    localparam logic [2:0] c_op_lsl = 3'b001;
    localparam logic [2:0] c_op_lsr = 3'b010;
    localparam logic [2:0] c_op_asr = 3'b011;
    localparam logic [2:0] c_op_ror = 3'b100;
    localparam logic [2:0] c_op_rol = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_wr;
    logic [AW-1:0]     r_rem;
    logic [2:0]        r_op;
    logic              r_lo;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_sout;
    logic              r_carry;

    logic [c_kw-1:0]   w_k;
    logic [AW-1:0]     w_rem_next;
    logic [AW-1:0]     w_idx_hi;
    logic [AW-1:0]     w_idx_lo;
    logic [WIDTH-1:0]  w_wr_sh;
    logic              w_lo;
    logic              w_is_shift;
    logic [AW-1:0]     w_load_rem;

    always_comb begin
        w_is_shift = (op >= c_op_lsl) && (op <= c_op_rol);
        w_load_rem = w_is_shift ? amt : '0;

        // k never exceeds rem, so the narrowing casts below cannot lose bits
        w_k        = (c_kw'(r_rem) < c_step) ? c_kw'(r_rem) : c_step;
        w_rem_next = r_rem - AW'(w_k);
        w_idx_hi   = AW'(c_width - w_k);
        w_idx_lo   = AW'(w_k - 1'b1);

        w_wr_sh = r_wr;
        w_lo    = 1'b0;
        case (r_op)
            c_op_lsl: begin
                w_wr_sh = r_wr << w_k;
                w_lo    = r_wr[w_idx_hi];
            end
            c_op_lsr: begin
                w_wr_sh = r_wr >> w_k;
                w_lo    = r_wr[w_idx_lo];
            end
            c_op_asr: begin
                w_wr_sh = WIDTH'($signed(r_wr) >>> w_k);
                w_lo    = r_wr[w_idx_lo];
            end
            c_op_ror: begin
                w_wr_sh = (r_wr >> w_k) | (r_wr << (c_width - w_k));
                w_lo    = r_wr[w_idx_lo];
            end
            c_op_rol: begin
                w_wr_sh = (r_wr << w_k) | (r_wr >> (c_width - w_k));
                w_lo    = r_wr[w_idx_hi];
            end
            default: begin
                w_wr_sh = r_wr;
                w_lo    = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_load_rem == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_next = (w_rem_next == '0) ? S_DONE : S_SHIFT;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wr    <= '0;
            r_rem   <= '0;
            r_op    <= '0;
            r_lo    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sout  <= '0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wr  <= in;
                        r_op  <= op;
                        r_rem <= w_load_rem;
                        r_lo  <= 1'b0;
                        // zero-length operations complete straight away
                        if (w_load_rem == '0) begin
                            r_sout  <= in;
                            r_carry <= 1'b0;
                        end
                    end
                end
                S_SHIFT: begin
                    r_wr  <= w_wr_sh;
                    r_lo  <= w_lo;
                    r_rem <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_sout  <= w_wr_sh;
                        r_carry <= w_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sout  = r_sout;
    assign carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_shifter                                               |
// | Description : Self-checking bench for seq_shifter, STEP=1 and STEP=4.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        start [2];
    logic [15:0] din   [2];
    logic [3:0]  amt   [2];
    logic [2:0]  opr   [2];
    logic        busy  [2];
    logic        done  [2];
    logic [15:0] sout  [2];
    logic        carry [2];

    int errors = 0;
    int checks = 0;

    seq_shifter #(.WIDTH(16), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .in(din[0]), .amt(amt[0]),
        .op(opr[0]), .busy(busy[0]), .done(done[0]), .sout(sout[0]), .carry(carry[0])
    );

    seq_shifter #(.WIDTH(16), .STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .in(din[1]), .amt(amt[1]),
        .op(opr[1]), .busy(busy[1]), .done(done[1]), .sout(sout[1]), .carry(carry[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: one-bit steps repeated n times; carry is the final bit dropped/rotated out
    function automatic logic [16:0] model(input logic [2:0] o, input logic [15:0] x, input int n);
        logic [15:0] w;
        logic        c;
        int          m;
        w = x;
        c = 1'b0;
        m = (o >= 3'd1 && o <= 3'd5) ? n : 0;
        for (int i = 0; i < m; i++) begin
            case (o)
                3'd1: begin c = w[15]; w = {w[14:0], 1'b0}; end
                3'd2: begin c = w[0];  w = {1'b0, w[15:1]}; end
                3'd3: begin c = w[0];  w = {w[15], w[15:1]}; end
                3'd4: begin c = w[0];  w = {w[0], w[15:1]}; end
                default: begin c = w[15]; w = {w[14:0], w[15]}; end
            endcase
        end
        return {c, w};
    endfunction

    function automatic int latency(input logic [2:0] o, input int n, input int step);
        int m;
        m = (o >= 3'd1 && o <= 3'd5) ? n : 0;
        return 1 + (m + step - 1) / step;
    endfunction

    task automatic run_op(input int sel, input logic [2:0] o, input logic [15:0] x,
                          input logic [3:0] n, input bit intrude);
        logic [16:0] exp;
        logic [15:0] prev;
        int          lat;
        int          cyc;
        bit          seen;
        bit          stable;
        bit          busy_ok;
        exp     = model(o, x, int'(n));
        lat     = latency(o, int'(n), (sel == 0) ? 1 : 4);
        prev    = sout[sel];
        @(negedge clk);
        start[sel] = 1'b1; din[sel] = x; amt[sel] = n; opr[sel] = o;
        @(negedge clk);
        start[sel] = 1'b0;
        din[sel]   = 16'($urandom);
        amt[sel]   = 4'($urandom);
        opr[sel]   = 3'($urandom);
        cyc = 1; seen = 0; stable = 1; busy_ok = 1;
        while (!seen && cyc <= 40) begin
            if (intrude) begin
                start[sel] = (cyc == 2);
                if (cyc == 2) begin din[sel] = 16'h1111; amt[sel] = 4'd1; opr[sel] = 3'd2; end
            end
            if (done[sel] === 1'b1) seen = 1;
            else begin
                if (sout[sel] !== prev) stable = 0;
                if (busy[sel] !== 1'b1) busy_ok = 0;
                cyc++;
                @(negedge clk);
            end
        end
        start[sel] = 1'b0;
        check($sformatf("done_seen[%0d]", sel), 32'(seen), 32'd1);
        check($sformatf("latency[%0d] op%0d n%0d", sel, o, n), 32'(cyc), 32'(lat));
        check($sformatf("sout[%0d] op%0d %h>>%0d", sel, o, x, n), 32'(sout[sel]), 32'(exp[15:0]));
        check($sformatf("carry[%0d] op%0d %h>>%0d", sel, o, x, n), 32'(carry[sel]), 32'(exp[16]));
        check($sformatf("busy_at_done[%0d]", sel), 32'(busy[sel]), 32'd1);
        check($sformatf("sout_stable[%0d]", sel), 32'(stable), 32'd1);
        check($sformatf("busy_during[%0d]", sel), 32'(busy_ok), 32'd1);
        @(negedge clk);
        check($sformatf("done_pulse[%0d]", sel), 32'(done[sel]), 32'd0);
        check($sformatf("busy_idle[%0d]", sel), 32'(busy[sel]), 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0; din[s] = '0; amt[s] = '0; opr[s] = '0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst_busy[%0d]", s), 32'(busy[s]), 32'd0);
            check($sformatf("rst_done[%0d]", s), 32'(done[s]), 32'd0);
            check($sformatf("rst_sout[%0d]", s), 32'(sout[s]), 32'd0);
            check($sformatf("rst_carry[%0d]", s), 32'(carry[s]), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy[0] | busy[1]), 32'd0);
            check("idle_done", 32'(done[0] | done[1]), 32'd0);
        end

        // Single-step logical/arithmetic shifts
        run_op(0, 3'd1, 16'h8421, 4'd3, 0);
        check("vec_lsl", 32'(sout[0]), 32'h2108);
        run_op(0, 3'd2, 16'h8421, 4'd3, 0);
        check("vec_lsr", 32'(sout[0]), 32'h1084);
        run_op(0, 3'd3, 16'h8421, 4'd3, 0);
        check("vec_asr", 32'(sout[0]), 32'hF084);
        check("vec_asr_c", 32'(carry[0]), 32'd0);

        // Rotates on the wide-step instance
        run_op(1, 3'd4, 16'h1234, 4'd5, 0);
        check("vec_ror", 32'(sout[1]), 32'hA091);
        check("vec_ror_c", 32'(carry[1]), 32'd1);
        run_op(1, 3'd5, 16'h1234, 4'd5, 0);
        check("vec_rol", 32'(sout[1]), 32'h4682);

        // Zero-length and pass-through cases
        run_op(0, 3'd0, 16'hC3A5, 4'd7, 0);
        check("vec_pass", 32'(sout[0]), 32'hC3A5);
        run_op(1, 3'd1, 16'h5A5A, 4'd0, 0);
        run_op(1, 3'd6, 16'h0F0F, 4'd9, 0);
        run_op(0, 3'd7, 16'h1357, 4'd15, 0);
        run_op(0, 3'd5, 16'h8001, 4'd15, 0);
        run_op(1, 3'd3, 16'h8000, 4'd15, 0);

        // Start pulsed mid-operation must be ignored
        run_op(0, 3'd4, 16'hBEEF, 4'd9, 1);
        run_op(1, 3'd3, 16'hBEEF, 4'd13, 1);

        // Start held high: second op accepted after one IDLE cycle
        @(negedge clk);
        start[0] = 1'b1; din[0] = 16'h8001; amt[0] = 4'd2; opr[0] = 3'd5;
        @(negedge clk);
        din[0] = 16'h00F0; amt[0] = 4'd3; opr[0] = 3'd2;
        cyc = 1; seen = 0;
        while (!seen && cyc <= 40) begin
            if (done[0] === 1'b1) seen = 1; else begin cyc++; @(negedge clk); end
        end
        check("held1_lat", 32'(cyc), 32'd3);
        check("held1_sout", 32'(sout[0]), 32'h0006);
        check("held1_carry", 32'(carry[0]), 32'd0);
        @(negedge clk);
        check("held_gap_busy", 32'(busy[0]), 32'd0);
        check("held_gap_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        start[0] = 1'b0;
        check("held2_busy", 32'(busy[0]), 32'd1);
        cyc = 1; seen = 0;
        while (!seen && cyc <= 40) begin
            if (done[0] === 1'b1) seen = 1; else begin cyc++; @(negedge clk); end
        end
        check("held2_lat", 32'(cyc), 32'd4);
        check("held2_sout", 32'(sout[0]), 32'h001E);
        check("held2_carry", 32'(carry[0]), 32'd0);
        @(negedge clk);

        // Reset in the middle of a long shift
        @(negedge clk);
        start[0] = 1'b1; din[0] = 16'hFFFF; amt[0] = 4'd15; opr[0] = 3'd1;
        @(negedge clk);
        start[0] = 1'b0;
        seen = 0;
        for (int i = 1; i < 6; i++) begin
            if (done[0] === 1'b1) seen = 1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_sout", 32'(sout[0]), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done[0] === 1'b1) seen = 1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done[0] === 1'b1) seen = 1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_sout_held", 32'(sout[0]), 32'd0);
        check("abort_carry", 32'(carry[0]), 32'd0);
        run_op(0, 3'd1, 16'h00FF, 4'd4, 0);
        run_op(1, 3'd4, 16'hF00D, 4'd11, 0);

        // Randomized operations on both instances
        for (int i = 0; i < 40; i++) begin
            run_op(i % 2, 3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom_range(0, 15)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
